bcd_stopwatch: RTL
==================

# bcd_stopwatch

Parametrised multi-digit BCD stopwatch. Merges the clock-divider and decade-counter functions into one sequential block. A prescaler derives a hundredth-second tick from the system clock. A cascaded chain of `DIGITS` BCD decade counters accumulates ticks under a run/stop/clear control FSM. Each digit drives a 7-segment pattern through a `bcd7seg` instance, so the block sits between the debounced pushbutton logic and the HEX displays of the top level.

## Interface
- `DIV`, default 500000: clocks per hundredth-second tick (50 MHz). Legal range is ≥2.
- `DIGITS`, default 4: number of cascaded BCD digits. Legal range is 2–8.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start_stop` in 1: single-cycle synchronous pulse that toggles between RUN and STOP.
- `clr` in 1: single-cycle pulse that zeroes the count. Acted on only in STOP.
- `lap` in 1: single-cycle pulse that toggles lap hold. Present only with `BCD_STOPWATCH_LAP_EN`.
- `running` out 1: 1 in RUN.
- `tick` out 1: one-cycle pulse at each hundredth boundary while running.
- `rollover` out 1: one-cycle pulse when all digits wrap from 9…9 to 0…0.
- `digits` out 4*DIGITS: displayed BCD value. Nibble 0 (LSBs) is hundredths.
- `seg` out 7*DIGITS: per-digit segment pattern from `bcd7seg`. Slice i corresponds to nibble i.

## Operation
- FSM has two states, STOP and RUN. Reset state is STOP.
  - STOP with `start_stop` goes to RUN.
  - RUN with `start_stop` goes to STOP.
- Prescaler `divcnt` is $clog2(DIV) bits wide.
  - In RUN it counts 0..DIV-1 and wraps to 0.
  - In STOP it holds its value, so a partial hundredth is preserved across stop/restart.
- `tick` is defined as RUN && `divcnt`==DIV-1.
- Digit chain behaviour:
  - Digit i increments on `tick` when all digits below i equal 9.
  - A digit at 9 that increments wraps to 0.
  - All digits at 9 on `tick` causes every digit to go to 0 and asserts `rollover`. Counting continues.
- `clr` in STOP sets `divcnt` and all digits to 0. `clr` in RUN is ignored.
- `clr` and `start_stop` in the same STOP cycle: the clear applies and the state goes to RUN, so counting starts from 0 on the next cycle.
- Digits hold only 0–9; no other BCD value is ever reachable.
- `seg` is combinational from `digits`.

## Timing
- Reset values are all 0: `running`, `tick`, `rollover`, `digits`, `divcnt`. `seg` shows "0" on every digit.
- `rst` asserted mid-run clears everything asynchronously. After deassertion the block is in STOP and waits for `start_stop`.
- `running` changes the cycle after the `start_stop` pulse.
- The first `tick` after leaving reset or `clr` occurs DIV clocks after the first RUN cycle.
- Digit registers update on the clock edge that ends the `tick` cycle. `digits` shows the new value the following cycle.
- `rollover` is coincident with the `tick` that causes the wrap.
- A `start_stop` pulse in the same cycle as `tick` has two effects:
  - The tick increment still occurs.
  - The state goes to STOP, and `divcnt` holds at 0.

## Configuration
- `BCD_STOPWATCH_LAP_EN` defined: adds the `lap` port, a lap register of 4*DIGITS bits, and a hold flag.
  - In RUN, `lap` with hold=0 captures the live count and sets hold=1.
  - `lap` with hold=1 clears hold.
  - While hold=1, `digits` and `seg` show the captured value and the live count continues internally.
  - `lap` in STOP is ignored.
  - `clr` in STOP also clears hold.
  - `tick` and `rollover` always follow the live count.
- `BCD_STOPWATCH_LAP_EN` undefined: no `lap` port and no lap logic. `digits` always shows the live count.

## Test plan
All scenarios use DIV=4, DIGITS=3.
- Reset and run:
  - Stimulus: `start_stop`, then 40 clocks.
  - Required response: 10 `tick` pulses, `digits`=12'h010, `seg` slice 1 shows "1".
- Stop/resume partial:
  - Stimulus: run 6 clocks (1 tick, `divcnt`=2), stop, idle 20 clocks, restart.
  - Required response: next `tick` exactly 2 clocks after RUN resumes, and `digits`=12'h002.
- Rollover:
  - Stimulus: run 4000 clocks from 0.
  - Required response: `rollover` pulses with the 1000th tick, and `digits` returns to 12'h000.
- Clear rules:
  - Stimulus: `clr` in RUN.
  - Required response: count unchanged.
  - Stimulus: `clr` + `start_stop` together in STOP.
  - Required response: `digits`=0, `running`=1, first tick 4 clocks later.
- Async reset mid-run:
  - Stimulus: assert `rst` at `digits`=12'h057, not aligned to `clk`.
  - Required response: all outputs 0 immediately, `running`=0 after release.
- Lap (`BCD_STOPWATCH_LAP_EN`):
  - Stimulus: `lap` at `digits`=12'h025, then 20 clocks.
  - Required response: display stays 12'h025.
  - Stimulus: `lap` again.
  - Required response: display shows 12'h030.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - BCD stopwatch: hundredth prescaler, decade chain, run/stop FSM, 7-seg decode
// Optional lap hold enabled by BCD_STOPWATCH_LAP_EN; segments are active-high {g,f,e,d,c,b,a}.

module bcd7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

module bcd_stopwatch #(
    parameter int DIV    = 500000,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clr,
`ifdef BCD_STOPWATCH_LAP_EN
    input  logic                  lap,
`endif
    output logic                  running,
    output logic                  tick,
    output logic                  rollover,
    output logic [4*DIGITS-1:0]   digits,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {STOP, RUN} state_t;

    state_t              state, state_next;
    logic [DW-1:0]       divcnt, divcnt_next;
    logic [4*DIGITS-1:0] count, count_next;
    logic                carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STOP;
            divcnt <= '0;
            count  <= '0;
        end else begin
            state  <= state_next;
            divcnt <= divcnt_next;
            count  <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_stop)
            state_next = (state == STOP) ? RUN : STOP;
    end

    assign running = (state == RUN);
    assign tick    = running && (divcnt == DIV_LAST);

    // Ripple carry: digit i advances only when every lower digit is wrapping from 9.
    always_comb begin
        divcnt_next = divcnt;
        count_next  = count;
        carry       = tick;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry)
                count_next[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
            carry = carry && (count[4*i +: 4] == 4'd9);
        end
        rollover = carry;
        if (running) begin
            divcnt_next = tick ? '0 : divcnt + DW'(1);
        end else if (clr) begin
            divcnt_next = '0;
            count_next  = '0;
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic [4*DIGITS-1:0] lap_value;
    logic                hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_value <= '0;
            hold      <= 1'b0;
        end else if (running && lap) begin
            if (!hold)
                lap_value <= count;
            hold <= !hold;
        end else if (!running && clr) begin
            hold <= 1'b0;
        end
    end

    assign digits = hold ? lap_value : count;
`else
    assign digits = count;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd7seg u_bcd7seg (
            .bcd (digits[4*g +: 4]),
            .seg (seg[7*g +: 7])
        );
    end
endmodule
